macaw_mc: RTL and testbench

Multi-channel sparse multiply-accumulate unit for the PE block. It holds one activation flag block and NUM_CH weight flag blocks. For each channel it walks the positions where both the activation and that channel's weight are non-zero, and emits compressed-buffer offsets for each one. It then accumulates the returned activation×weight products into a per-channel saturating accumulator. It generalises the single-channel MAC: channel count, data width, block depth and accumulator width are parameters, and it adds per-channel handshakes, a selectable accumulator init and saturation.

---
 rtl/macaw_mc_pkg.sv | 50 +++++
 rtl/macaw_mc_flg_offset_gen.sv | 62 ++++++
 rtl/macaw_mc.sv | 99 +++++++++
 tb/tb_macaw_mc.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/macaw_mc_pkg.sv
// Shared widths and arithmetic helpers for the macaw_mc sparse multi-channel MAC.
package macaw_mc_pkg;

   localparam int SAT_W = 64;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      return r;
   endfunction

   // Room for 3*depth worst-case products without wrapping.
   function automatic int acc_width(input int data_w, input int depth);
      return 2 * data_w + clog2(3 * depth);
   endfunction

   localparam int DEF_DATA_WIDTH  = 8;
   localparam int DEF_BLOCK_DEPTH = 32;
   localparam int DEF_ACC_WIDTH   = acc_width(DEF_DATA_WIDTH, DEF_BLOCK_DEPTH);

   typedef struct packed {
      logic [SAT_W-1:0] val;
      logic             sat;
   } sat_res_t;

   // Operands arrive sign-extended to SAT_W; result is clamped to an acc_w-bit signed range.
   function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] acc,
                                        input logic signed [SAT_W-1:0] prod,
                                        input int                      acc_w);
      logic signed [SAT_W-1:0] sum;
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      sat_res_t                res;
      sum     = acc + prod;
      hi      = (SAT_W'(1) << (acc_w - 1)) - SAT_W'(1);
      lo      = ~hi;
      res.val = sum;
      res.sat = 1'b0;
      if (sum > hi) begin
         res.val = hi;
         res.sat = 1'b1;
      end else if (sum < lo) begin
         res.val = lo;
         res.sat = 1'b1;
      end
      return res;
   endfunction

endpackage

// File: rtl/macaw_mc_flg_offset_gen.sv
// Per-channel match walker: holds the joint non-zero mask and presents compressed
// buffer offsets for the lowest remaining match.
module macaw_mc_flg_offset_gen
   import macaw_mc_pkg::*;
#(
   parameter int BLOCK_DEPTH = 32,
   parameter int OFF_WIDTH   = clog2(BLOCK_DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   sta,
   input  logic [BLOCK_DEPTH-1:0] flg_act,
   input  logic [BLOCK_DEPTH-1:0] flg_wei,
   input  logic                   aw_val,
   output logic                   off_val,
   output logic [OFF_WIDTH-1:0]   off_act,
   output logic [OFF_WIDTH-1:0]   off_wei,
   output logic                   fnh,
   output logic                   take
);

   logic                   started;
   logic [BLOCK_DEPTH-1:0] mask_q;
   logic [BLOCK_DEPTH-1:0] act_q;
   logic [BLOCK_DEPTH-1:0] wei_q;
   logic [BLOCK_DEPTH-1:0] low;
   logic [BLOCK_DEPTH-1:0] below;

   function automatic logic [OFF_WIDTH-1:0] popcnt(input logic [BLOCK_DEPTH-1:0] v);
      logic [OFF_WIDTH-1:0] n;
      n = '0;
      for (int i = 0; i < BLOCK_DEPTH; i++) n = n + OFF_WIDTH'(v[i]);
      return n;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         started <= 1'b0;
         mask_q  <= '0;
         act_q   <= '0;
         wei_q   <= '0;
      end else if (sta) begin
         started <= 1'b1;
         mask_q  <= flg_act & flg_wei;
         act_q   <= flg_act;
         wei_q   <= flg_wei;
      end else if (take) begin
         mask_q  <= mask_q & ~low;
      end
   end

   // One-hot of the current match position; everything below it feeds the popcounts.
   assign low     = mask_q & (~mask_q + BLOCK_DEPTH'(1));
   assign below   = off_val ? (low - BLOCK_DEPTH'(1)) : '0;

   assign off_val = started & (|mask_q);
   assign fnh     = started & ~(|mask_q);
   assign off_act = popcnt(act_q & below);
   assign off_wei = popcnt(wei_q & below);
   assign take    = aw_val & off_val & ~sta;

endmodule

// File: rtl/macaw_mc.sv
// macaw_mc: NUM_CH weight channels share one activation flag block; each channel walks
// its matches and accumulates the returned products with saturation.
module macaw_mc
   import macaw_mc_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int BLOCK_DEPTH = 32,
   parameter int NUM_CH      = 4,
   parameter int OFF_WIDTH   = clog2(BLOCK_DEPTH),
   parameter int ACC_WIDTH   = acc_width(DATA_WIDTH, BLOCK_DEPTH)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          sta,
   input  logic                          init_zero,
   input  logic [BLOCK_DEPTH-1:0]        flg_act,
   input  logic [NUM_CH*BLOCK_DEPTH-1:0] flg_wei,
   input  logic [NUM_CH*ACC_WIDTH-1:0]   acc_in,
   input  logic [NUM_CH*DATA_WIDTH-1:0]  act,
   input  logic [NUM_CH*DATA_WIDTH-1:0]  wei,
   input  logic [NUM_CH-1:0]             aw_val,
   output logic [NUM_CH-1:0]             off_val,
   output logic [NUM_CH*OFF_WIDTH-1:0]   off_act,
   output logic [NUM_CH*OFF_WIDTH-1:0]   off_wei,
   output logic [NUM_CH-1:0]             fnh,
   output logic                          done,
   output logic [NUM_CH*ACC_WIDTH-1:0]   acc_out,
   output logic [NUM_CH-1:0]             sat_flg
);

   logic armed_q;

   // Armed by sta, disarmed by the done it produces, so done pulses once per start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      armed_q <= 1'b0;
      else if (sta)    armed_q <= 1'b1;
      else if (done)   armed_q <= 1'b0;
   end

   assign done = armed_q & (&fnh);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic                    take;
      logic [DATA_WIDTH-1:0]   a;
      logic [DATA_WIDTH-1:0]   w;
      logic [2*DATA_WIDTH-1:0] a_ext;
      logic [2*DATA_WIDTH-1:0] w_ext;
      logic [2*DATA_WIDTH-1:0] prod;
      logic [ACC_WIDTH-1:0]    acc_q;
      logic                    sat_q;
      sat_res_t                res;
      logic                    unused_hi;

      macaw_mc_flg_offset_gen #(
         .BLOCK_DEPTH (BLOCK_DEPTH),
         .OFF_WIDTH   (OFF_WIDTH)
      ) u_gen (
         .clk     (clk),
         .rst_n   (rst_n),
         .sta     (sta),
         .flg_act (flg_act),
         .flg_wei (flg_wei[c*BLOCK_DEPTH +: BLOCK_DEPTH]),
         .aw_val  (aw_val[c]),
         .off_val (off_val[c]),
         .off_act (off_act[c*OFF_WIDTH +: OFF_WIDTH]),
         .off_wei (off_wei[c*OFF_WIDTH +: OFF_WIDTH]),
         .fnh     (fnh[c]),
         .take    (take)
      );

      assign a     = act[c*DATA_WIDTH +: DATA_WIDTH];
      assign w     = wei[c*DATA_WIDTH +: DATA_WIDTH];
      assign a_ext = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
      assign w_ext = {{DATA_WIDTH{w[DATA_WIDTH-1]}}, w};
      // Low 2*DATA_WIDTH bits of the sign-extended product are the exact signed product.
      assign prod  = a_ext * w_ext;
      assign res   = sat_add({{(SAT_W-ACC_WIDTH){acc_q[ACC_WIDTH-1]}}, acc_q},
                             {{(SAT_W-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod},
                             ACC_WIDTH);
      assign unused_hi = ^res.val[SAT_W-1:ACC_WIDTH];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            acc_q <= '0;
            sat_q <= 1'b0;
         end else if (sta) begin
            acc_q <= init_zero ? '0 : acc_in[c*ACC_WIDTH +: ACC_WIDTH];
            sat_q <= 1'b0;
         end else if (take) begin
            acc_q <= res.val[ACC_WIDTH-1:0];
            sat_q <= sat_q | res.sat;
         end
      end

      assign acc_out[c*ACC_WIDTH +: ACC_WIDTH] = acc_q;
      assign sat_flg[c]                        = sat_q;
   end

endmodule

// File: tb/tb_macaw_mc.sv
// Scoreboard bench for macaw_mc: expected offsets are queued when sta is issued and
// a negedge monitor pops/compares them, tracking accumulators with plain integer math.
module tb_macaw_mc;

   localparam int DW  = 8;
   localparam int BD  = 32;
   localparam int NC  = 4;
   localparam int OW  = 5;
   localparam int AW  = 23;
   localparam int AIW = NC * AW;
   localparam longint MAXV = 4194303;
   localparam longint MINV = -4194304;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            sta = 1'b0;
   logic            init_zero = 1'b0;
   logic [BD-1:0]   flg_act = '0;
   logic [NC*BD-1:0] flg_wei = '0;
   logic [AIW-1:0]  acc_in = '0;
   logic [NC*DW-1:0] act = '0;
   logic [NC*DW-1:0] wei = '0;
   logic [NC-1:0]   aw_val = '0;
   logic [NC-1:0]   off_val;
   logic [NC*OW-1:0] off_act;
   logic [NC*OW-1:0] off_wei;
   logic [NC-1:0]   fnh;
   logic            done;
   logic [AIW-1:0]  acc_out;
   logic [NC-1:0]   sat_flg;

   macaw_mc #(
      .DATA_WIDTH (DW), .BLOCK_DEPTH (BD), .NUM_CH (NC), .OFF_WIDTH (OW), .ACC_WIDTH (AW)
   ) dut (
      .clk (clk), .rst_n (rst_n), .sta (sta), .init_zero (init_zero),
      .flg_act (flg_act), .flg_wei (flg_wei), .acc_in (acc_in), .act (act), .wei (wei),
      .aw_val (aw_val), .off_val (off_val), .off_act (off_act), .off_wei (off_wei),
      .fnh (fnh), .done (done), .acc_out (acc_out), .sat_flg (sat_flg)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   int          exp_oa[NC][$];
   int          exp_ow[NC][$];
   int          pend_oa[NC][$];
   int          pend_ow[NC][$];
   longint      acc_m[NC];
   longint      pend_acc[NC];
   bit          sat_m[NC];
   bit          started_m = 1'b0;
   bit          armed_m = 1'b0;
   logic [BD-1:0] cfg_wei[NC];
   logic [AW-1:0] cfg_acc[NC];

   task automatic chk(input string name, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Monitor / reference model, evaluated mid-cycle.
   always @(negedge clk) begin
      bit     all_fnh;
      bit     done_e;
      bit     ov;
      longint s;
      if (!rst_n) begin
         started_m = 1'b0;
         armed_m   = 1'b0;
         for (int c = 0; c < NC; c++) begin
            exp_oa[c].delete();
            exp_ow[c].delete();
            acc_m[c] = 0;
            sat_m[c] = 1'b0;
         end
      end
      all_fnh = started_m;
      for (int c = 0; c < NC; c++) if (exp_oa[c].size() != 0) all_fnh = 1'b0;
      done_e = armed_m && all_fnh;
      for (int c = 0; c < NC; c++) begin
         ov = started_m && (exp_oa[c].size() != 0);
         chk($sformatf("off_val[%0d]", c), off_val[c], ov);
         chk($sformatf("fnh[%0d]", c), fnh[c], started_m && !ov);
         chk($sformatf("acc_out[%0d]", c), $signed(acc_out[c*AW +: AW]), acc_m[c]);
         chk($sformatf("sat_flg[%0d]", c), sat_flg[c], sat_m[c]);
         if (ov) begin
            chk($sformatf("off_act[%0d]", c), off_act[c*OW +: OW], exp_oa[c][0]);
            chk($sformatf("off_wei[%0d]", c), off_wei[c*OW +: OW], exp_ow[c][0]);
         end
      end
      chk("done", done, done_e);
      if (rst_n) begin
         if (done_e) armed_m = 1'b0;
         if (sta) begin
            started_m = 1'b1;
            armed_m   = 1'b1;
            for (int c = 0; c < NC; c++) begin
               exp_oa[c] = pend_oa[c];
               exp_ow[c] = pend_ow[c];
               acc_m[c]  = pend_acc[c];
               sat_m[c]  = 1'b0;
            end
         end else begin
            for (int c = 0; c < NC; c++) begin
               if (aw_val[c] && started_m && exp_oa[c].size() != 0) begin
                  void'(exp_oa[c].pop_front());
                  void'(exp_ow[c].pop_front());
                  s = acc_m[c] + longint'($signed(act[c*DW +: DW])) * longint'($signed(wei[c*DW +: DW]));
                  if (s > MAXV) begin
                     s = MAXV;
                     sat_m[c] = 1'b1;
                  end else if (s < MINV) begin
                     s = MINV;
                     sat_m[c] = 1'b1;
                  end
                  acc_m[c] = s;
               end
            end
         end
      end
   end

   // Issue sta with cfg_wei/cfg_acc; the expected match list is queued here.
   task automatic do_sta(input logic [BD-1:0] fa, input bit iz, input logic [NC-1:0] aw);
      logic [BD-1:0] below;
      @(posedge clk); #1;
      sta = 1'b1; flg_act = fa; init_zero = iz; aw_val = aw;
      act = $urandom; wei = $urandom;
      for (int c = 0; c < NC; c++) begin
         flg_wei[c*BD +: BD] = cfg_wei[c];
         acc_in[c*AW +: AW]  = cfg_acc[c];
         pend_oa[c].delete();
         pend_ow[c].delete();
         for (int p = 0; p < BD; p++) begin
            if (fa[p] && cfg_wei[c][p]) begin
               below = (BD'(1) << p) - BD'(1);
               pend_oa[c].push_back($countones(fa & below));
               pend_ow[c].push_back($countones(cfg_wei[c] & below));
            end
         end
         pend_acc[c] = iz ? 0 : longint'($signed(cfg_acc[c]));
      end
   endtask

   // One non-start cycle; flag/init inputs are scrambled to prove they were captured.
   task automatic tick(input logic [NC-1:0] aw, input logic [NC*DW-1:0] a, input logic [NC*DW-1:0] w);
      @(posedge clk); #1;
      sta = 1'b0; aw_val = aw; act = a; wei = w;
      flg_act   = $urandom;
      flg_wei   = {$urandom, $urandom, $urandom, $urandom};
      acc_in    = AIW'({$urandom, $urandom, $urandom});
      init_zero = 1'($urandom);
   endtask

   // mode 0: every channel accepts act=wei=1 each cycle; mode 1: random handshakes/data.
   task automatic run_to_done(input int budget, input int mode, input logic [NC-1:0] block, output int n);
      logic [NC-1:0]    aw;
      logic [NC*DW-1:0] a;
      logic [NC*DW-1:0] w;
      bit               seen;
      seen = 1'b0;
      n = 0;
      for (int i = 1; i <= budget && !seen; i++) begin
         if (mode == 0) begin
            aw = '1; a = {NC{8'd1}}; w = {NC{8'd1}};
         end else begin
            aw = NC'($urandom); a = $urandom; w = $urandom;
         end
         tick(aw & ~block, a, w);
         if (done) begin
            seen = 1'b1;
            n = i;
         end
      end
      chk("done_seen", seen, 1);
   endtask

   task automatic clear_cfg();
      for (int c = 0; c < NC; c++) begin
         cfg_wei[c] = '0;
         cfg_acc[c] = '0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_off_val", off_val, 0);
      chk("rst_fnh", fnh, 0);
      chk("rst_done", done, 0);
      chk("rst_acc", acc_out, 0);
      rst_n = 1'b1;
      tick('1, $urandom, $urandom);

      // Single match: act 0xB, wei 0x6 -> position 1, offsets (1,0); 3 * -5.
      clear_cfg();
      cfg_wei[0] = 32'h0000_0006;
      do_sta(32'h0000_000B, 1'b1, '0);
      tick(4'b0001, 32'h0000_0003, 32'h0000_00FB);
      chk("t1_off_act", off_act[OW-1:0], 1);
      chk("t1_off_wei", off_wei[OW-1:0], 0);
      chk("t1_off_val", off_val, 4'b0001);
      tick('0, '0, '0);
      chk("t1_acc", $signed(acc_out[AW-1:0]), -15);
      chk("t1_fnh", fnh, 4'hF);
      chk("t1_done", done, 1);

      // All flags zero: done right after sta, acc preloaded.
      for (int c = 0; c < NC; c++) begin
         cfg_wei[c] = $urandom;
         cfg_acc[c] = AW'($urandom);
      end
      do_sta('0, 1'b0, '1);
      run_to_done(5, 1, '0, n);
      chk("zero_done_cycle", n, 1);
      for (int c = 0; c < NC; c++)
         chk($sformatf("zero_acc[%0d]", c), acc_out[c*AW +: AW], cfg_acc[c]);

      // Full block, one accept per cycle.
      for (int c = 0; c < NC; c++) cfg_wei[c] = '1;
      do_sta('1, 1'b1, '1);
      run_to_done(60, 0, '0, n);
      chk("full_done_cycle", n, 33);
      chk("full_acc0", acc_out[AW-1:0], 32);

      // Saturation then a negative product pulling back from max.
      clear_cfg();
      cfg_wei[0] = 32'h3;
      cfg_acc[0] = AW'(MAXV - 100);
      do_sta(32'h3, 1'b0, '1);
      tick(4'b0001, 32'h0000_007F, 32'h0000_007F);
      tick(4'b0001, 32'h0000_00FE, 32'h0000_0003);
      tick('0, '0, '0);
      chk("sat_acc", $signed(acc_out[AW-1:0]), MAXV - 6);
      chk("sat_flg", sat_flg[0], 1);
      chk("sat_done", done, 1);

      // Independence: ch1 stalled while ch0 finishes.
      clear_cfg();
      cfg_wei[0] = 32'h0F;
      cfg_wei[1] = 32'hF0;
      do_sta(32'hFF, 1'b1, '0);
      for (int i = 0; i < 10; i++) begin
         tick(4'b0001, {NC{8'd2}}, {NC{8'd3}});
         chk("indep_no_done", done, 0);
      end
      chk("indep_ch0_fnh", fnh[0], 1);
      run_to_done(20, 0, '0, n);
      chk("indep_done_cycle", n, 5);

      // Abort mid-run and restart; aw_val high in the sta cycle.
      for (int c = 0; c < NC; c++) cfg_wei[c] = '1;
      do_sta($urandom, 1'b1, '1);
      repeat (5) tick('1, $urandom, $urandom);
      for (int c = 0; c < NC; c++) cfg_wei[c] = $urandom;
      do_sta($urandom, 1'b0, '1);
      run_to_done(400, 1, '0, n);

      // Randomized starts, including accumulators near the limits.
      for (int it = 0; it < 30; it++) begin
         for (int c = 0; c < NC; c++) begin
            cfg_wei[c] = (it % 3 == 0) ? $urandom : ($urandom & $urandom);
            case ($urandom_range(0, 3))
               0:       cfg_acc[c] = AW'(MAXV - $urandom_range(0, 20000));
               1:       cfg_acc[c] = AW'(MINV + $urandom_range(0, 20000));
               default: cfg_acc[c] = AW'($urandom);
            endcase
         end
         do_sta($urandom | $urandom, 1'($urandom), NC'($urandom));
         run_to_done(400, 1, '0, n);
         repeat ($urandom_range(0, 2)) tick(NC'($urandom), $urandom, $urandom);
      end

      // Asynchronous reset between edges mid-operation.
      for (int c = 0; c < NC; c++) begin
         cfg_wei[c] = '1;
         cfg_acc[c] = AW'($urandom);
      end
      do_sta('1, 1'b0, '0);
      repeat (3) tick('1, $urandom, $urandom);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("arst_off_val", off_val, 0);
      chk("arst_off_act", off_act, 0);
      chk("arst_off_wei", off_wei, 0);
      chk("arst_fnh", fnh, 0);
      chk("arst_done", done, 0);
      chk("arst_acc", acc_out, 0);
      chk("arst_sat", sat_flg, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick('1, $urandom, $urandom);
      for (int c = 0; c < NC; c++) cfg_wei[c] = $urandom;
      do_sta($urandom, 1'b1, '1);
      run_to_done(400, 1, '0, n);
      repeat (2) tick('0, '0, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
